// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_pkg
// Description : Shared types and constants for the CRC generator/checker.
//               - state_t  : FSM encoding {IDLE, RUN, DONE}
//               - COUNT_W  : beat counter / message length width
//               - Named generator polynomials (implicit top term omitted)
// Revision    : 1.0 - initial release
// ============================================================================
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int COUNT_W = 16;

  localparam logic [15:0] CRC16_8005     = 16'h8005;
  localparam logic [31:0] CRC32_04C11DB7 = 32'h04C11DB7;

endpackage : crc_pkg
`default_nettype wire

// File: rtl/crc_step.sv
`default_nettype none
// ============================================================================
// Module      : crc_step
// Description : Combinational CRC update for one beat of DATA_W bits.
//               Bits are folded in MSB-first (data_i[DATA_W-1] first).
// Ports       : crc_in_i   [WIDTH-1:0]  current CRC register
//               data_i     [DATA_W-1:0] message beat
//               crc_next_o [WIDTH-1:0]  register after applying the beat
// Revision    : 1.0 - initial release
// ============================================================================
module crc_step #(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] POLY   = 16'h8005,
  parameter int               DATA_W = 1
) (
  input  logic [WIDTH-1:0]  crc_in_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [WIDTH-1:0]  crc_next_o
);

  always_comb begin
    logic [WIDTH-1:0] r;
    logic             fb;
    r  = crc_in_i;
    fb = 1'b0;
    // Unrolled serial LFSR: one shift per data bit within a single cycle.
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = r[WIDTH-1] ^ data_i[i];
      r  = {r[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    crc_next_o = r;
  end

endmodule : crc_step
`default_nettype wire

// File: rtl/crc_gen_chk.sv
`default_nettype none
// ============================================================================
// Module      : crc_gen_chk
// Description : Parameterised CRC generator / checker. A start pulse presets
//               the register, latches the message length and the expected
//               CRC; beats are then consumed one per clock until len beats
//               have been accepted, after which done and crc_ok are raised.
// Ports       : clck_i      clock (rising edge)
//               rst_n_i     asynchronous active-low reset
//               start_i     begin (or restart) a message
//               len_i       message length in beats, sampled on start
//               in_valid_i  beat valid
//               in_data_i   beat data, MSB processed first
//               in_ready_o  beat accepted this cycle when valid
//               exp_crc_i   expected CRC, sampled on start
//               crc_out_o   running register XOR XOR_OUT
//               done_o      message complete
//               crc_ok_o    final crc_out matches expected CRC
// Revision    : 1.0 - initial release
// ============================================================================
module crc_gen_chk
  import crc_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] POLY    = CRC16_8005,
  parameter logic [WIDTH-1:0] INIT    = 16'hFFFF,
  parameter logic [WIDTH-1:0] XOR_OUT = 16'h0000,
  parameter int               DATA_W  = 1
) (
  input  logic               clck_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [COUNT_W-1:0] len_i,
  input  logic               in_valid_i,
  input  logic [DATA_W-1:0]  in_data_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   exp_crc_i,
  output logic [WIDTH-1:0]   crc_out_o,
  output logic               done_o,
  output logic               crc_ok_o
);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     crc_q,   crc_d;
  logic [COUNT_W-1:0]   cnt_q,   cnt_d;
  logic [COUNT_W-1:0]   len_q,   len_d;
  logic [WIDTH-1:0]     exp_q,   exp_d;
  logic                 ok_q,    ok_d;
  logic [WIDTH-1:0]     crc_next;

  crc_step #(
    .WIDTH  (WIDTH),
    .POLY   (POLY),
    .DATA_W (DATA_W)
  ) u_step (
    .crc_in_i   (crc_q),
    .data_i     (in_data_i),
    .crc_next_o (crc_next)
  );

  always_ff @(posedge clck_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      cnt_q   <= '0;
      len_q   <= '0;
      exp_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      exp_q   <= exp_d;
      ok_q    <= ok_d;
    end
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    exp_d   = exp_q;
    ok_d    = ok_q;
    // start wins over everything, including a beat offered in the same cycle.
    if (start_i) begin
      state_d = RUN;
      crc_d   = INIT;
      cnt_d   = '0;
      len_d   = len_i;
      exp_d   = exp_crc_i;
      ok_d    = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (cnt_q == len_q) begin
            // Final register is already settled; compare on the DONE edge.
            state_d = DONE;
            ok_d    = ((crc_q ^ XOR_OUT) == exp_q);
          end else if (in_valid_i) begin
            crc_d = crc_next;
            cnt_d = cnt_q + COUNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o = (state_q == RUN) && (cnt_q < len_q);
  assign crc_out_o  = crc_q ^ XOR_OUT;
  assign done_o     = (state_q == DONE);
  assign crc_ok_o   = ok_q;

endmodule : crc_gen_chk
`default_nettype wire

// File: doc/crc_gen_chk.md
CRC_GEN_CHK -- requirements
Module: crc_gen_chk

Interface
REQ-001 Parameter WIDTH, default 16, CRC register width; legal 8..32.
REQ-002 Parameter POLY, default 16'h8005, generator polynomial with the implicit x^WIDTH term omitted; WIDTH bits.
REQ-003 Parameter INIT, default 16'hFFFF, register preset value loaded on start; WIDTH bits.
REQ-004 Parameter XOR_OUT, default 16'h0000, final XOR applied to crc_out; WIDTH bits.
REQ-005 Parameter DATA_W, default 1, input bits consumed per accepted beat; legal 1, 2, 4, 8.
REQ-006 clck  input  1  system clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 start  input  1  synchronous pulse: preset register to INIT, latch len, latch exp_crc, enter RUN.
REQ-009 len  input  16  number of DATA_W-bit beats in the message; sampled only on start.
REQ-010 in_valid  input  1  in_data holds a valid beat.
REQ-011 in_data  input  DATA_W  message beat; bit DATA_W-1 is processed first.
REQ-012 in_ready  output  1  block accepts a beat this cycle.
REQ-013 exp_crc  input  WIDTH  expected CRC for check mode; sampled only on start.
REQ-014 crc_out  output  WIDTH  running register XOR XOR_OUT; the final result is valid while done=1.
REQ-015 done  output  1  message complete; held high until the next start or reset.
REQ-016 crc_ok  output  1  (final crc_out == latched exp_crc); valid only while done=1, 0 otherwise.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start.
- RUN -> DONE when the beat counter reaches the latched len.
- DONE -> RUN on start.
- Any state -> IDLE on reset.
REQ-018 in_ready = 1 only in RUN with beat counter < latched len; a beat is accepted when in_valid & in_ready.
REQ-019 Per-bit update, MSB-first: fb = R[WIDTH-1] ^ d; R = {R[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0).
REQ-020 All DATA_W bits of one accepted beat are applied within one cycle, in order from bit DATA_W-1 down to bit 0; throughput is one beat per clock.
REQ-021 The beat counter is 16 bits wide, cleared on start, and incremented by 1 per accepted beat; it never wraps because acceptance stops at len.
REQ-022 Latency: done rises on the clock edge following the edge that accepts the final beat; crc_ok is registered on that same edge.
REQ-023 len = 0: the block enters RUN, accepts no beats, and asserts done on the next edge with crc_out = INIT ^ XOR_OUT.
REQ-024 When in_valid = 0 in RUN, register, counter and state all hold (stall); stalls of any length are legal.
REQ-025 start in RUN aborts the current message and restarts from INIT with the new len; a beat presented in the same cycle is discarded.
REQ-026 start in DONE clears done and crc_ok on that edge.
REQ-027 in_valid is ignored in IDLE and DONE.

Reset
REQ-028 When rst_n = 0, the block enters IDLE immediately, without waiting for a clock edge.
REQ-029 Reset values: register = INIT, counter = 0, done = 0, crc_ok = 0, in_ready = 0, latched len = 0, latched exp_crc = 0.
REQ-030 Reset mid-message discards all progress; after reset the block produces no output until the next start.

Structure
REQ-031 A shared package crc_pkg holds:
- state enum {IDLE, RUN, DONE};
- localparam COUNT_W = 16;
- named polynomial constants CRC16_8005 and CRC32_04C11DB7.
REQ-032 One sub-module, crc_step: combinational, parameters WIDTH, POLY, DATA_W; inputs crc_in and data; output crc_next implementing REQ-019/REQ-020. It is instantiated once.

Verification
REQ-033 Default parameters, start with len=0 -> done one cycle later; crc_out=16'hFFFF; crc_ok=1 when exp_crc=16'hFFFF.
REQ-034 Default parameters, len=1:
- in_data=0 -> crc_out=16'h7FFB.
- in_data=1 -> crc_out=16'hFFFE.
REQ-035 DATA_W=8, len=9, ASCII "123456789" -> crc_out=16'hAEE7; with exp_crc=16'hAEE7, crc_ok=1; with exp_crc=16'hAEE6, crc_ok=0.
REQ-036 WIDTH=32, POLY=32'h04C11DB7, INIT=32'hFFFFFFFF, DATA_W=8, "123456789" fed with random in_valid gaps -> crc_out=32'h0376E6E7; in_ready drops after beat 9.
REQ-037 Abort and reset:
- start again after 4 beats of a 9-beat run, then feed the full "123456789" -> 16'hAEE7.
- rst_n low mid-run -> done=0 and in_ready=0 immediately, with no clock edge.
